// File: rtl/jesd204_tpl_dac_fifo_ram.sv
// Sample storage for the DAC DMA FIFO.
// Simple dual-port RAM: synchronous write, registered read that holds when idle.
module jesd204_tpl_dac_fifo_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/jesd204_tpl_dac_dma_fifo.sv
// DMA-to-TPL-DAC elastic buffer: prefills START_LEVEL beats, then serves one beat per
// DAC request with one-cycle latency; an empty request yields zero data and dac_dunf.
module jesd204_tpl_dac_dma_fifo #(
  parameter int DATA_WIDTH   = 128,
  parameter int NUM_CHANNELS = 2,
  parameter int ADDR_WIDTH   = 4,
  parameter int START_LEVEL  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_CHANNELS-1:0] dac_valid,
  output logic [DATA_WIDTH-1:0]   dac_ddata,
  output logic                    dac_dunf,
  output logic [ADDR_WIDTH:0]     level
);
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] START_L = START_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0]   ram_q;
  logic                    push, pop, unf, zero_q;
  logic                    run_on;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // next state
  always_comb begin
    state_next = state;
    if (~|enable) state_next = ST_IDLE;
    else begin
      case (state)
        ST_IDLE: state_next = ST_FILL;
        ST_FILL: if (level >= START_L) state_next = ST_RUN;
        default: state_next = state;
      endcase
    end
  end

  // outputs / strobes decoded from state
  always_comb begin
    run_on  = (state == ST_RUN) && (|dac_valid);
    s_ready = (state != ST_IDLE) && (level != DEPTH_L);
    push    = s_valid && s_ready;
    pop     = run_on && (level != '0);
    unf     = run_on && (level == '0);
  end

  // pointers and occupancy; a stopped stream flushes everything
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE || ~|enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

  // zero_q masks the RAM output outside RUN and on underflow, so stale or
  // pre-reset contents never reach the DAC
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q   <= 1'b1;
      dac_dunf <= 1'b0;
    end else begin
      dac_dunf <= unf;
      if (state != ST_RUN || unf) zero_q <= 1'b1;
      else if (pop)               zero_q <= 1'b0;
    end
  end

  assign dac_ddata = zero_q ? '0 : ram_q;

  jesd204_tpl_dac_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );
endmodule

// File: tb/tb_jesd204_tpl_dac_dma_fifo.sv
// Directed bench for the DAC DMA FIFO: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_jesd204_tpl_dac_dma_fifo;
  localparam int START = 8;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   enable = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic [1:0]   dac_valid = '0;
  logic [127:0] dac_ddata;
  logic         dac_dunf;
  logic [4:0]   level;

  int total = 0;
  int bad   = 0;

  jesd204_tpl_dac_dma_fifo #(
    .DATA_WIDTH(128), .NUM_CHANNELS(2), .ADDR_WIDTH(4), .START_LEVEL(START)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .dac_valid(dac_valid), .dac_ddata(dac_ddata), .dac_dunf(dac_dunf),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: 0=stopped, 1=prefilling, 2=streaming
  int           mst = 0;
  logic [127:0] mq[$];
  logic [127:0] m_dd = '0;
  logic         m_unf = 1'b0;
  bit           started = 1'b0;

  always @(posedge clk) begin : model
    int sz;
    bit rdy, psh, req;
    sz = mq.size();
    if (reset) begin
      mst = 0; mq.delete(); m_dd = '0; m_unf = 1'b0;
    end else begin
      rdy = (mst != 0) && (sz < DEPTH);
      psh = s_valid && rdy;
      req = |dac_valid;
      m_unf = 1'b0;
      if (mst != 2) m_dd = '0;
      else if (req) begin
        if (sz > 0) m_dd = mq.pop_front();
        else begin m_dd = '0; m_unf = 1'b1; end
      end
      if (psh) mq.push_back(s_data);
      if (enable == 2'b00) begin mst = 0; mq.delete(); end
      else if (mst == 0) mst = 1;
      else if (mst == 1 && sz >= START) mst = 2;
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_level", 128'(level), 128'(mq.size()));
      chk("m_s_ready", 128'(s_ready), 128'((mst != 0) && (mq.size() < DEPTH)));
      chk("m_ddata", dac_ddata, m_dd);
      chk("m_dunf", 128'(dac_dunf), 128'(m_unf));
    end
  end

  task automatic step(input logic [1:0] en, input logic sv, input logic [127:0] d,
                      input logic [1:0] dv);
    enable = en; s_valid = sv; s_data = d; dac_valid = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 128'(level), 0);
    chk("rst_ready", 128'(s_ready), 0);
    chk("rst_ddata", dac_ddata, 0);
    chk("rst_dunf", 128'(dac_dunf), 0);
    reset = 1'b0;

    // prefill 8 beats, requests in FILL are ignored
    step(2'b11, 0, 0, 0);
    chk("fill_ready", 128'(s_ready), 1);
    for (int i = 1; i <= 8; i++) step(2'b11, 1, 128'(i), 0);
    chk("fill_level8", 128'(level), 8);
    chk("fill_ddata0", dac_ddata, 0);
    step(2'b11, 0, 0, 2'b11);
    chk("fill_req_ignored", 128'(level), 8);
    chk("fill_no_dunf", 128'(dac_dunf), 0);

    // streaming: one push and one pop per cycle
    for (int i = 1; i <= 8; i++) begin
      step(2'b11, 1, 128'(8 + i), 2'b01);
      chk("run_ddata", dac_ddata, 128'(i));
      chk("run_level", 128'(level), 8);
      chk("run_dunf", 128'(dac_dunf), 0);
    end

    // fill to full
    for (int i = 17; i <= 24; i++) step(2'b11, 1, 128'(i), 0);
    chk("full_level", 128'(level), 16);
    chk("full_ready", 128'(s_ready), 0);
    step(2'b11, 1, 128'h99, 2'b10);
    chk("full_pop_dd", dac_ddata, 128'h9);
    chk("full_pop_level", 128'(level), 15);
    chk("full_pop_ready", 128'(s_ready), 1);

    // drain, then underflow for three cycles
    for (int i = 10; i <= 24; i++) begin
      step(2'b11, 0, 0, 2'b11);
      chk("drain_dd", dac_ddata, 128'(i));
    end
    chk("drain_level0", 128'(level), 0);
    for (int k = 0; k < 3; k++) begin
      step(2'b11, 0, 0, 2'b11);
      chk("unf_dunf", 128'(dac_dunf), 1);
      chk("unf_dd", dac_ddata, 0);
    end
    step(2'b11, 0, 0, 0);
    chk("unf_end", 128'(dac_dunf), 0);
    step(2'b11, 1, 128'h50, 2'b01);
    chk("no_bypass_dunf", 128'(dac_dunf), 1);
    chk("no_bypass_dd", dac_ddata, 0);
    chk("no_bypass_level", 128'(level), 1);

    // stop with level 5 flushes, restart sees only new beats
    for (int i = 1; i <= 4; i++) step(2'b11, 1, 128'(8'h50 + i), 0);
    chk("pre_stop_level", 128'(level), 5);
    step(2'b00, 0, 0, 0);
    chk("stop_level", 128'(level), 0);
    chk("stop_ready", 128'(s_ready), 0);
    step(2'b11, 0, 0, 0);
    chk("restart_ready", 128'(s_ready), 1);
    for (int i = 0; i < 8; i++) step(2'b11, 1, 128'(16'h200 + i), 0);
    step(2'b11, 0, 0, 0);
    step(2'b11, 0, 0, 2'b01);
    chk("restart_first", dac_ddata, 128'h200);

    // reset mid-stream with level 10
    for (int i = 0; i < 3; i++) step(2'b11, 1, 128'(16'h300 + i), 0);
    chk("pre_rst_level", 128'(level), 10);
    reset = 1'b1;
    step(2'b11, 1, 128'hdead, 2'b01);
    chk("mid_rst_level", 128'(level), 0);
    chk("mid_rst_ready", 128'(s_ready), 0);
    chk("mid_rst_dd", dac_ddata, 0);
    chk("mid_rst_dunf", 128'(dac_dunf), 0);
    reset = 1'b0;
    step(2'b11, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(2'b11, 1, 128'(16'h400 + i), 0);
    step(2'b11, 0, 0, 0);
    step(2'b11, 0, 0, 2'b01);
    chk("post_rst_first", dac_ddata, 128'h400);
    step(2'b11, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
